timer_share_ctrl: RTL and testbench
===================================

TIMER_SHARE_CTRL -- requirements
Module: timer_share_ctrl

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..8).
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req  in  NREQ  per-requester delay request; level, held until the matching done bit.
REQ-005 req_delay  in  32*NREQ  per-requester delay in clocks; slice i = bits [32*i+31:32*i].
REQ-006 done  out  NREQ  one-cycle completion pulse per requester.
REQ-007 busy  out  1  high whenever the state is not IDLE.
REQ-008 grant_id  out  clog2(NREQ)  index of the requester currently owning the timer.
REQ-009 tmr_address  out  3  timer slave register address.
REQ-010 tmr_chipselect  out  1  timer slave select.
REQ-011 tmr_write_n  out  1  timer slave write strobe, active-low.
REQ-012 tmr_writedata  out  16  timer slave write data.
REQ-013 tmr_irq  in  1  timer interrupt; level, cleared by a write to status (address 0).

Function
REQ-014 Arbitration SHALL be in IDLE only, round-robin: search starts at the index after the last grant, with index 0 first after reset.
REQ-015 At grant, the block SHALL latch req_delay of the winner into delay_q and set grant_id.
REQ-016 Each timer access SHALL be a single-cycle write: tmr_chipselect=1, tmr_write_n=0. The timer has no waitrequest.
REQ-017 When not writing: tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
REQ-018 Sequence states: IDLE -> STOP (addr 1, data 0x0008) -> PL (addr 2, delay_q-1 [15:0]) -> PH (addr 3, delay_q-1 [31:16]) -> START (addr 1, data 0x0005) -> WAIT -> CLR (addr 0, data 0) -> DONE -> IDLE.
REQ-019 Each write state SHALL last exactly one cycle. Grant occurs at edge G; the STOP write is presented in cycle G+1; the START write in cycle G+4.
REQ-020 WAIT SHALL exit to CLR on the first cycle tmr_irq=1.
REQ-021 DONE SHALL pulse done[grant_id] for exactly one cycle, then return to IDLE. A new grant is possible on the following edge.
REQ-022 The programmed period SHALL be delay_q-1, so the interval from START write to irq is delay_q timer clocks.
REQ-023 delay_q==0 SHALL go directly from grant to DONE with no timer writes.
REQ-024 delay_q==1 SHALL program period 0 and follow the normal sequence.
REQ-025 Requests that arrive while busy SHALL wait. Simultaneous requests SHALL be resolved by the round-robin order, never dropped.
REQ-026 tmr_irq asserted outside WAIT SHALL be ignored. The CLR write of the next sequence clears it.
REQ-027 Subtraction SHALL be 32-bit unsigned.

Reset
REQ-028 On reset_n=0, immediately: state=IDLE, done=0, busy=0, grant_id=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, delay_q=0, round-robin pointer=0.
REQ-029 Reset mid-sequence SHALL abandon the sequence without issuing further writes.

Configuration
REQ-030 With TIMER_SHARE_CTRL_CANCEL_EN defined: if req[grant_id] drops in PL, PH, START or WAIT, the block SHALL go to ABORT (addr 1, data 0x0008), then CLR, then IDLE, with no done pulse.
REQ-031 Without TIMER_SHARE_CTRL_CANCEL_EN: req deassertion after grant SHALL be ignored, the sequence SHALL complete and done SHALL pulse.

Verification
REQ-032 Single request: req=0001, delay 50000 -> writes (1,0x0008),(2,0xC34F),(3,0x0000),(1,0x0005); model irq 50000 clocks later -> write (0,0); done[0] pulses once.
REQ-033 Contention: req=1111 held, delay 10 each -> done order 0,1,2,3. Re-assert req0 only after done[0]; it is then served after 3.
REQ-034 Zero delay: req[2]=1, delay 0 -> done[2] within 2 cycles of grant; no tmr_chipselect activity.
REQ-035 Stale irq: irq held high during the STOP/PL/PH/START writes -> ignored; CLR is issued only after WAIT is entered.
REQ-036 Cancel: drop req[1] in WAIT -> with the macro, writes (1,0x0008) then (0,0) and no done; without the macro, done[1] pulses after irq.
REQ-037 Reset during WAIT -> all outputs return to their reset values at once; the next request restarts at STOP.

Source files
------------

// File: rtl/timer_share_ctrl.sv
// rtl/timer_share_ctrl.sv - round-robin sharing of one interval timer among NREQ delay requesters
// Optional request cancellation is enabled by defining TIMER_SHARE_CTRL_CANCEL_EN.
module timer_share_ctrl #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_delay,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [IW-1:0]        grant_id,
  output logic [2:0]           tmr_address,
  output logic                 tmr_chipselect,
  output logic                 tmr_write_n,
  output logic [15:0]          tmr_writedata,
  input  logic                 tmr_irq
);

  typedef enum logic [3:0] {
    S_IDLE, S_STOP, S_PL, S_PH, S_START, S_WAIT, S_CLR, S_DONE, S_ABORT, S_ACLR
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   delay_q, delay_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic [31:0]   win_delay;
  logic [31:0]   period;
  logic          cancel;
  logic          wr_en;

  // Search starts at rr_q and wraps, so the previous winner is considered last.
  always_comb begin : arb
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  assign win_delay = req_delay[32*int'(win_idx) +: 32];
  assign period    = delay_q - 32'd1;

`ifdef TIMER_SHARE_CTRL_CANCEL_EN
  assign cancel = ~req[gid_q];
`else
  assign cancel = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: if (win_found) begin
        gid_d   = win_idx;
        delay_d = win_delay;
        rr_d    = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
        state_d = (win_delay == 32'd0) ? S_DONE : S_STOP;
      end
      S_STOP:  state_d = S_PL;
      S_PL:    state_d = cancel ? S_ABORT : S_PH;
      S_PH:    state_d = cancel ? S_ABORT : S_START;
      S_START: state_d = cancel ? S_ABORT : S_WAIT;
      S_WAIT:  if (cancel) state_d = S_ABORT;
               else if (tmr_irq) state_d = S_CLR;
      S_CLR:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_ACLR;
      S_ACLR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      delay_q <= '0;
      gid_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
    end
  end

  // Timer bus is decoded straight from the state: each write state is one bus cycle.
  always_comb begin
    wr_en         = 1'b0;
    tmr_address   = 3'd0;
    tmr_writedata = 16'h0000;
    done          = '0;
    case (state_q)
      S_STOP, S_ABORT: begin wr_en = 1'b1; tmr_address = 3'd1; tmr_writedata = 16'h0008; end
      S_PL:    begin wr_en = 1'b1; tmr_address = 3'd2; tmr_writedata = period[15:0]; end
      S_PH:    begin wr_en = 1'b1; tmr_address = 3'd3; tmr_writedata = period[31:16]; end
      S_START: begin wr_en = 1'b1; tmr_address = 3'd1; tmr_writedata = 16'h0005; end
      S_CLR, S_ACLR: wr_en = 1'b1;
      S_DONE:  done[gid_q] = 1'b1;
      default: ;
    endcase
  end

  assign tmr_chipselect = wr_en;
  assign tmr_write_n    = ~wr_en;
  assign busy           = (state_q != S_IDLE);
  assign grant_id       = gid_q;

endmodule

// File: tb/tb_timer_share_ctrl.sv
// tb/tb_timer_share_ctrl.sv - self-checking bench for timer_share_ctrl with a behavioural timer and requester model
module tb_timer_share_ctrl;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic [32*N-1:0] req_delay = '0;
  logic [N-1:0]   done;
  logic           busy;
  logic [1:0]     grant_id;
  logic [2:0]     tmr_address;
  logic           tmr_chipselect;
  logic           tmr_write_n;
  logic [15:0]    tmr_writedata;
  logic           tmr_irq;
  logic           timer_irq = 1'b0;
  logic           stale_irq = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cs_cnt = 0;
  int busy_rise = 0;
  logic busy_prev = 1'b0;
  logic [15:0] t_pl = '0, t_ph = '0;
  longint t_cnt = 0;

  logic [18:0] wr_q[$];
  int          wr_cyc[$];
  int          done_q[$];
  int          done_cyc[$];
  logic [18:0] exp_wr[$];
  int          exp_done[$];
  int          wb, db;
  int          exp_ptr;

  assign tmr_irq = timer_irq | stale_irq;

  timer_share_ctrl #(.NREQ(N)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_delay(req_delay),
    .done(done), .busy(busy), .grant_id(grant_id),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave model plus bus/done logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      timer_irq = 1'b0;
      t_cnt     = 0;
      busy_prev = 1'b0;
    end else begin
      if (t_cnt != 0) begin
        t_cnt = t_cnt - 1;
        if (t_cnt == 0) timer_irq = 1'b1;
      end
      if (tmr_chipselect) cs_cnt++;
      if (tmr_chipselect && !tmr_write_n) begin
        wr_q.push_back({tmr_address, tmr_writedata});
        wr_cyc.push_back(cyc);
        case (tmr_address)
          3'd0: timer_irq = 1'b0;
          3'd2: t_pl = tmr_writedata;
          3'd3: t_ph = tmr_writedata;
          3'd1: begin
            if (tmr_writedata == 16'h0005) t_cnt = longint'({t_ph, t_pl}) + 1;
            if (tmr_writedata == 16'h0008) t_cnt = 0;
          end
          default: ;
        endcase
      end
      if (busy && !busy_prev) busy_rise = cyc;
      busy_prev = busy;
      for (int i = 0; i < N; i++) if (done[i]) begin
        done_q.push_back(i);
        done_cyc.push_back(cyc);
      end
    end
  end

  function automatic void push_seq(input logic [31:0] d);
    logic [31:0] p;
    p = d - 32'd1;
    if (d != 0) begin
      exp_wr.push_back({3'd1, 16'h0008});
      exp_wr.push_back({3'd2, p[15:0]});
      exp_wr.push_back({3'd3, p[31:16]});
      exp_wr.push_back({3'd1, 16'h0005});
      exp_wr.push_back({3'd0, 16'h0000});
    end
  endfunction

  function automatic bit wr_ok();
    if (wr_q.size() - wb != exp_wr.size()) return 1'b0;
    for (int k = 0; k < exp_wr.size(); k++) if (wr_q[wb+k] !== exp_wr[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic mark();
    wb = wr_q.size();
    db = done_q.size();
    exp_wr.delete();
    exp_done.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0;
    stale_irq = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_ptr = 0;
  endtask

  // Requesters drop their req on seeing their own done bit.
  task automatic wait_dones(input int n, input int budget, output bit ok);
    int cnt;
    cnt = 0;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cnt += $countones(done);
      req = req & ~done;
      if (cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (wr_q.size() - wb >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({done, busy, grant_id, tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata} !== {4'b0, 1'b0, 2'b0, 3'b0, 1'b0, 1'b1, 16'h0}) begin
      bad++;
      $display("FAIL reset_outputs got done=%b busy=%b gid=%0d addr=%0d cs=%b wn=%b data=%h", done, busy, grant_id, tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata);
    end
    do_reset();
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    mark();
    req_delay[31:0] = 32'd50000;
    req = 4'b0001;
    wait_dones(1, 60000, ok);
    repeat (3) @(negedge clk);
    push_seq(32'd50000);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout done not seen"); end
    total++; if (!wr_ok()) begin bad++; $display("FAIL single_writes got %0d writes exp %0d", wr_q.size() - wb, exp_wr.size()); end
    total++; if (done_q.size() - db !== 1 || done_q[db] !== 0) begin bad++; $display("FAIL single_done got count=%0d exp 1 of idx 0", done_q.size() - db); end
    total++; if (wr_cyc[wb] !== busy_rise) begin bad++; $display("FAIL single_stop_cycle got=%0d exp=%0d", wr_cyc[wb], busy_rise); end
    total++; if (wr_cyc[wb+3] - wr_cyc[wb] !== 3) begin bad++; $display("FAIL single_start_cycle got=%0d exp=3", wr_cyc[wb+3] - wr_cyc[wb]); end
    total++; if (wr_cyc[wb+4] - wr_cyc[wb+3] !== 50001) begin bad++; $display("FAIL single_irq_interval got=%0d exp=50001", wr_cyc[wb+4] - wr_cyc[wb+3]); end
    total++; if (done_cyc[db] - wr_cyc[wb+4] !== 1) begin bad++; $display("FAIL single_done_cycle got=%0d exp=1", done_cyc[db] - wr_cyc[wb+4]); end
  endtask

  task automatic test_contention();
    bit ok1, ok2;
    do_reset();
    mark();
    req_delay = {4{32'd10}};
    req = 4'b1111;
    wait_dones(1, 200, ok1);
    @(negedge clk);
    req[0] = 1'b1;
    wait_dones(4, 500, ok2);
    repeat (3) @(negedge clk);
    exp_done = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) push_seq(32'd10);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL contention_timeout"); end
    total++; if (done_q.size() - db !== 5) begin bad++; $display("FAIL contention_count got=%0d exp=5", done_q.size() - db); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (done_q[db+k] !== exp_done[k]) begin bad++; $display("FAIL contention_order[%0d] got=%0d exp=%0d", k, done_q[db+k], exp_done[k]); end
    end
    total++; if (!wr_ok()) begin bad++; $display("FAIL contention_writes got %0d exp %0d", wr_q.size() - wb, exp_wr.size()); end
  endtask

  task automatic test_zero_delay();
    bit ok;
    int csb;
    do_reset();
    mark();
    csb = cs_cnt;
    req_delay = {32'd9, 32'd0, 32'd9, 32'd9};
    req = 4'b0100;
    wait_dones(1, 20, ok);
    repeat (3) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL zero_timeout"); end
    total++; if (done_q.size() - db !== 1 || done_q[db] !== 2) begin bad++; $display("FAIL zero_done got count=%0d exp 1 of idx 2", done_q.size() - db); end
    total++; if (cs_cnt - csb !== 0) begin bad++; $display("FAIL zero_cs_activity got=%0d exp=0", cs_cnt - csb); end
    total++; if (done_cyc[db] - busy_rise > 1 || done_cyc[db] < busy_rise) begin bad++; $display("FAIL zero_latency got=%0d exp<=1", done_cyc[db] - busy_rise); end
  endtask

  task automatic test_stale_irq();
    bit ok;
    do_reset();
    mark();
    req_delay = {32'd7, 32'd3, 32'd3, 32'd3};
    stale_irq = 1'b1;
    req = 4'b1000;
    repeat (4) @(negedge clk);
    stale_irq = 1'b0;
    wait_dones(1, 100, ok);
    repeat (3) @(negedge clk);
    push_seq(32'd7);
    total++; if (!ok) begin bad++; $display("FAIL stale_timeout"); end
    total++; if (!wr_ok()) begin bad++; $display("FAIL stale_writes got %0d exp %0d", wr_q.size() - wb, exp_wr.size()); end
    total++; if (wr_cyc[wb+4] - wr_cyc[wb+3] !== 8) begin bad++; $display("FAIL stale_clr_delay got=%0d exp=8", wr_cyc[wb+4] - wr_cyc[wb+3]); end
    total++; if (done_q[db] !== 3) begin bad++; $display("FAIL stale_done_idx got=%0d exp=3", done_q[db]); end
  endtask

  task automatic test_cancel();
    bit ok;
    do_reset();
    mark();
    req_delay = {32'd5, 32'd5, 32'd30, 32'd5};
    req = 4'b0010;
    wait_writes(4, 20, ok);
    repeat (5) @(negedge clk);
    req[1] = 1'b0;
`ifdef TIMER_SHARE_CTRL_CANCEL_EN
    repeat (40) @(negedge clk);
    push_seq(32'd30);
    void'(exp_wr.pop_back());
    exp_wr.push_back({3'd1, 16'h0008});
    exp_wr.push_back({3'd0, 16'h0000});
    total++; if (done_q.size() - db !== 0) begin bad++; $display("FAIL cancel_no_done got=%0d exp=0", done_q.size() - db); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_idle got busy=%b exp=0", busy); end
`else
    wait_dones(1, 100, ok);
    repeat (3) @(negedge clk);
    push_seq(32'd30);
    total++; if (done_q.size() - db !== 1 || done_q[db] !== 1) begin bad++; $display("FAIL cancel_ignored_done got count=%0d exp 1 of idx 1", done_q.size() - db); end
`endif
    total++; if (!ok) begin bad++; $display("FAIL cancel_timeout"); end
    total++; if (!wr_ok()) begin bad++; $display("FAIL cancel_writes got %0d exp %0d", wr_q.size() - wb, exp_wr.size()); end
  endtask

  task automatic test_reset_wait();
    bit ok;
    do_reset();
    mark();
    req_delay = {32'd5, 32'h0002_0005, 32'd5, 32'd5};
    req = 4'b0100;
    wait_writes(4, 20, ok);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({done, busy, grant_id, tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata} !== {4'b0, 1'b0, 2'b0, 3'b0, 1'b0, 1'b1, 16'h0}) begin
      bad++;
      $display("FAIL reset_wait_outputs got done=%b busy=%b gid=%0d addr=%0d cs=%b wn=%b data=%h", done, busy, grant_id, tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata);
    end
    push_seq(32'h0002_0005);
    void'(exp_wr.pop_back());
    total++; if (!ok || !wr_ok()) begin bad++; $display("FAIL reset_wait_pre_writes got %0d exp %0d", wr_q.size() - wb, exp_wr.size()); end
    req_delay[95:64] = 32'd40;
    mark();
    @(negedge clk);
    reset_n = 1'b1;
    exp_ptr = 0;
    wait_dones(1, 200, ok);
    repeat (3) @(negedge clk);
    push_seq(32'd40);
    total++; if (!ok) begin bad++; $display("FAIL reset_wait_timeout"); end
    total++; if (!wr_ok()) begin bad++; $display("FAIL reset_wait_restart got %0d writes exp %0d", wr_q.size() - wb, exp_wr.size()); end
    total++; if (done_q[db] !== 2) begin bad++; $display("FAIL reset_wait_done_idx got=%0d exp=2", done_q[db]); end
  endtask

  task automatic test_random();
    bit ok;
    logic [N-1:0] mask;
    int unsigned d[N];
    int idx, last;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      mark();
      mask = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        d[i] = $urandom_range(0, 12);
        req_delay[32*i +: 32] = d[i];
      end
      last = exp_ptr;
      for (int k = 0; k < N; k++) begin
        idx = (exp_ptr + k) % N;
        if (mask[idx]) begin
          exp_done.push_back(idx);
          push_seq(d[idx]);
          last = idx;
        end
      end
      exp_ptr = (last + 1) % N;
      @(negedge clk);
      req = mask;
      wait_dones($countones(mask), 500, ok);
      repeat (3) @(negedge clk);
      total++; if (!ok || done_q.size() - db !== exp_done.size()) begin bad++; $display("FAIL random[%0d]_count got=%0d exp=%0d", it, done_q.size() - db, exp_done.size()); end
      for (int k = 0; k < exp_done.size(); k++) begin
        total++;
        if (done_q[db+k] !== exp_done[k]) begin bad++; $display("FAIL random[%0d]_order[%0d] got=%0d exp=%0d", it, k, done_q[db+k], exp_done[k]); end
      end
      total++; if (!wr_ok()) begin bad++; $display("FAIL random[%0d]_writes got %0d exp %0d", it, wr_q.size() - wb, exp_wr.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero_delay();
    test_stale_irq();
    test_cancel();
    test_reset_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
